// File: rtl/mont_redc.sv
`default_nettype none
// ============================================================================
// Module   : mont_redc
// Purpose  : Word-serial Montgomery reduction, result = t_in * 2^-WIDTH mod n.
//            Optional operand check enabled by defining MONT_REDC_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mont_redc #(
    parameter int WIDTH = 1024,
    parameter int WORD  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2*WIDTH-1:0]   t_in,
    input  logic [WIDTH-1:0]     n,
    input  logic [WORD-1:0]      n0p,
    output logic [WIDTH-1:0]     result,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int K  = WIDTH / WORD;
    localparam int CW = $clog2(K + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_SUB  = 2'd2;

    logic [1:0]           r_state;
    logic [2*WIDTH:0]     r_acc;
    logic [CW-1:0]        r_cnt;
    logic [WIDTH-1:0]     r_result;
    logic                 r_busy;
    logic                 r_done;

    logic [WORD-1:0]       w_m;
    logic [WIDTH+WORD-1:0] w_mn;
    logic [2*WIDTH:0]      w_sum;
    logic [2*WIDTH:0]      w_next;
    logic                  w_ge;
    logic [WIDTH-1:0]      w_red;

    // The sum cannot exceed 2*n*R while t_in < n*R, so 2*WIDTH+1 bits hold it.
    assign w_m    = r_acc[WORD-1:0] * n0p;
    assign w_mn   = {{WIDTH{1'b0}}, w_m} * {{WORD{1'b0}}, n};
    assign w_sum  = r_acc + {{(WIDTH+1-WORD){1'b0}}, w_mn};
    assign w_next = w_sum >> WORD;
    assign w_ge   = (r_acc >= {{(WIDTH+1){1'b0}}, n});
    assign w_red  = r_acc[WIDTH-1:0] - n;

`ifdef MONT_REDC_CHECK_EN
    logic            r_err;
    logic [WORD-1:0] w_inv_prod;
    logic            w_chk_ok;

    assign w_inv_prod = n0p * n[WORD-1:0];
    assign w_chk_ok   = n[0] && (w_inv_prod == {WORD{1'b1}});
    assign err        = r_err;
`else
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MONT_REDC_CHECK_EN
            r_err    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef MONT_REDC_CHECK_EN
                        r_err <= !w_chk_ok;
                        if (!w_chk_ok) begin
                            r_done   <= 1'b1;
                            r_result <= '0;
                        end else begin
                            r_acc   <= {1'b0, t_in};
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_ITER;
                        end
`else
                        r_acc   <= {1'b0, t_in};
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_ITER;
`endif
                    end
                end
                S_ITER: begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(K - 1)) begin
                        r_state <= S_SUB;
                    end
                end
                S_SUB: begin
                    r_result <= w_ge ? w_red : r_acc[WIDTH-1:0];
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign result = r_result;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
